// File: rtl/voice_mixer_if.sv
// Sample/control bundle between the oscillator slot stream and voice_mixer.
// The master side drives slot data and configuration; the slave side (the mixer) returns the mixed sample.
interface voice_mixer_if #(
    parameter int VOICES    = 8,
    parameter int OUT_WIDTH = 24
);
    logic                        frame_sync;
    logic signed [16:0]          sine_lut_out;
    logic [7:0]                  osc_level;
    logic [VOICES-1:0]           voice_free;
    logic [7:0]                  master_vol;
    logic signed [OUT_WIDTH-1:0] mix_out;
    logic                        mix_valid;
    logic                        clip;
    logic                        sync_err;

    modport master (
        output frame_sync, sine_lut_out, osc_level, voice_free, master_vol,
        input  mix_out, mix_valid, clip, sync_err
    );

    modport slave (
        input  frame_sync, sine_lut_out, osc_level, voice_free, master_vol,
        output mix_out, mix_valid, clip, sync_err
    );
endinterface

// File: rtl/voice_mixer.sv
// Time-slotted voice mixer: scales each oscillator slot by its level, sums a frame, applies master volume.
// Define MIXER_SATURATE_EN to clamp out-of-range samples and raise clip; otherwise the output wraps.
//
// state       | meaning
// ST_UNLOCKED | waiting for the first frame_sync, pipeline idle
// ST_RUN      | slot counter running, one mixed sample per frame
module voice_mixer #(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int V_WIDTH   = 3,
    parameter int O_WIDTH   = 2,
    parameter int OUT_WIDTH = 24,
    parameter int OUT_SHIFT = 4
) (
    input  logic          sCLK_XVXENVS,
    input  logic          reset_reg_N,
    voice_mixer_if.slave  bus
);
    localparam int SLOT_W = V_WIDTH + O_WIDTH;
    localparam int SLOTS  = VOICES * V_OSC;
    localparam int PW     = 39;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    typedef enum logic {ST_UNLOCKED, ST_RUN} state_t;

    state_t              state, state_next;
    logic [SLOT_W-1:0]   slot_cnt, slot_cnt_next, cur_slot;
    logic                slot_act;
    logic                resync;

    logic signed [24:0]  prod;
    logic signed [24:0]  p;
    logic [SLOT_W-1:0]   p_slot;
    logic                p_vld;

    logic signed [29:0]  acc, acc_next, sum_reg;
    logic                sum_vld;

    logic signed [PW-1:0]        scaled, shifted;
    logic signed [OUT_WIDTH-1:0] result;
    logic                        clip_set;

    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            state    <= ST_UNLOCKED;
            slot_cnt <= '0;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_cnt_next;
        end
    end

    // slot_cnt points at the slot expected next; frame_sync overrides it with slot 0.
    always_comb begin
        state_next    = state;
        slot_act      = 1'b0;
        cur_slot      = slot_cnt;
        resync        = 1'b0;
        slot_cnt_next = slot_cnt;
        case (state)
            ST_UNLOCKED: begin
                if (bus.frame_sync) begin
                    state_next = ST_RUN;
                    slot_act   = 1'b1;
                    cur_slot   = '0;
                end
            end
            ST_RUN: begin
                slot_act = 1'b1;
                if (bus.frame_sync) begin
                    cur_slot = '0;
                    resync   = (slot_cnt != '0);
                end
            end
            default: state_next = ST_UNLOCKED;
        endcase
        if (slot_act)
            slot_cnt_next = (cur_slot == LAST_SLOT) ? '0 : cur_slot + 1'b1;
    end

    assign prod = bus.sine_lut_out * $signed({1'b0, bus.osc_level});

    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            p      <= '0;
            p_slot <= '0;
            p_vld  <= 1'b0;
        end else begin
            p_vld  <= slot_act;
            p_slot <= cur_slot;
            p      <= (slot_act && !bus.voice_free[cur_slot[SLOT_W-1:O_WIDTH]]) ? prod : '0;
        end
    end

    // Slot 0 reloads the accumulator, so a frame cut short by a resync never reaches the latch.
    assign acc_next = (p_slot == '0) ? 30'(p) : acc + 30'(p);

    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            acc     <= '0;
            sum_reg <= '0;
            sum_vld <= 1'b0;
        end else begin
            sum_vld <= 1'b0;
            if (p_vld) begin
                acc <= acc_next;
                if (p_slot == LAST_SLOT) begin
                    sum_reg <= acc_next;
                    sum_vld <= 1'b1;
                end
            end
        end
    end

    assign scaled  = sum_reg * $signed({1'b0, bus.master_vol});
    assign shifted = (scaled >>> 8) >>> OUT_SHIFT;

`ifdef MIXER_SATURATE_EN
    localparam logic signed [PW-1:0] MAX_V = (PW'(1) <<< (OUT_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] MIN_V = -(PW'(1) <<< (OUT_WIDTH - 1));

    always_comb begin
        result   = shifted[OUT_WIDTH-1:0];
        clip_set = 1'b0;
        if (shifted > MAX_V) begin
            result   = MAX_V[OUT_WIDTH-1:0];
            clip_set = 1'b1;
        end else if (shifted < MIN_V) begin
            result   = MIN_V[OUT_WIDTH-1:0];
            clip_set = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[PW-1:OUT_WIDTH];
    assign result    = shifted[OUT_WIDTH-1:0];
    assign clip_set  = 1'b0;
`endif

    always_ff @(posedge sCLK_XVXENVS) begin
        if (!reset_reg_N) begin
            bus.mix_out   <= '0;
            bus.mix_valid <= 1'b0;
            bus.clip      <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.mix_valid <= sum_vld;
            if (sum_vld)
                bus.mix_out <= result;
            if (sum_vld && clip_set)
                bus.clip <= 1'b1;
            if (resync)
                bus.sync_err <= 1'b1;
        end
    end
endmodule
